// File: rtl/lpc_pkg.sv
// lpc_pkg: shared constants and types for the LPC host cycle generator.
//   - CYCTYPE/direction nibbles, target SYNC codes, completion status codes
//   - lpc_state_e: host FSM states (ABORT states exist only with LPC_HOST_TIMEOUT_EN)
//   - small decode helpers for the CYCTYPE nibble
package lpc_pkg;

    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] CYC_MEM_RD = 4'b0100;
    localparam logic [3:0] CYC_MEM_WR = 4'b0110;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    localparam logic [1:0] STAT_OK       = 2'b00;
    localparam logic [1:0] STAT_SYNC_ERR = 2'b01;
    localparam logic [1:0] STAT_ABORT    = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR_H1,
        ST_TAR_H2,
        ST_SYNC,
        ST_RDATA,
        ST_TAR_T1,
        ST_TAR_T2,
        ST_RESP
`ifdef LPC_HOST_TIMEOUT_EN
        ,
        ST_ABORT,
        ST_ABORT_END
`endif
    } lpc_state_e;

    function automatic logic is_mem(input logic [3:0] cyc);
        return cyc[3:2] == CYC_MEM_RD[3:2];
    endfunction

    function automatic logic is_write(input logic [3:0] cyc);
        return cyc[1] == CYC_IO_WR[1];
    endfunction

endpackage

// File: rtl/lpc_host_if.sv
// lpc_host_if: request/response handshake plus LAD/LFRAME# pins of the LPC host.
//   master : view used by lpc_host (accepts requests, drives the LPC bus)
//   slave  : view used by the requester / target model around the host
interface lpc_host_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir;
    logic [31:0] req_addr;
    logic [7:0]  req_data;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;
    logic [3:0]  lpc_ad_in;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic        lpc_frame;

    modport master (
        input  req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
        output req_ready, resp_valid, resp_data, resp_status,
               lpc_ad_out, lpc_ad_oe, lpc_frame
    );

    modport slave (
        output req_valid, req_cyctype_dir, req_addr, req_data, lpc_ad_in,
        input  req_ready, resp_valid, resp_data, resp_status,
               lpc_ad_out, lpc_ad_oe, lpc_frame
    );

endinterface

// File: rtl/lpc_sync_timer.sv
// lpc_sync_timer: counts cycles spent in the SYNC phase.
//   clock     : LPC clock
//   reset     : synchronous, active-high
//   run_i     : high while the host is in SYNC; low clears the count to 0
//   expired_o : high in the SYNC_TIMEOUT-th consecutive SYNC cycle
module lpc_sync_timer #(
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYNC_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lpc_host.sv
// lpc_host: LPC host cycle generator. Takes one I/O or memory request at a
// time, serialises it onto LFRAME#/LAD, handles turn-around and target SYNC,
// and returns read data with a completion status.
//   clock : LPC clock, rising edge
//   reset : synchronous, active-high
//   bus   : lpc_host_if.master (request/response handshake, LAD/LFRAME# pins)
// Parameter SYNC_TIMEOUT: SYNC cycles before abort (timeout build only).
// Optional feature macro LPC_HOST_TIMEOUT_EN: SYNC timeout with LFRAME# abort.
//
// state       | meaning
// ------------+--------------------------------------------------
// IDLE        | bus idle, req_ready high
// START       | LFRAME# low, LAD=0000
// CYCTYPE     | cycle type / direction nibble
// ADDR        | address nibbles, MSB first (4 I/O, 8 memory)
// WDATA       | write data nibbles, low first
// TAR_H1/H2   | host turn-around (drive 1111, then release)
// SYNC        | wait for target READY/ERROR
// RDATA       | sample read data nibbles, low first
// TAR_T1/T2   | target turn-around
// RESP        | one-cycle resp_valid
// ABORT       | LFRAME# low, LAD=1111 for 4 cycles (timeout build)
// ABORT_END   | bus released one cycle before RESP (timeout build)
module lpc_host
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    lpc_host_if.master  bus
);

    lpc_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sync_err_q, sync_err_d;
    logic [7:0]  resp_data_q, resp_data_d;
    logic [1:0]  resp_status_q, resp_status_d;

    logic        frame;
    logic        ad_oe;
    logic [3:0]  ad_out;
    logic        ready;
    logic        rvalid;

`ifdef LPC_HOST_TIMEOUT_EN
    logic tmo_expired;

    lpc_sync_timer #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) u_sync_timer (
        .clock     (clock),
        .reset     (reset),
        .run_i     (state_q == ST_SYNC),
        .expired_o (tmo_expired)
    );
`else
    logic unused_sync_timeout;
    assign unused_sync_timeout = (SYNC_TIMEOUT == 0);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cyc_d         = cyc_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        sync_err_d    = sync_err_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        frame         = 1'b1;
        ad_oe         = 1'b0;
        ad_out        = 4'hF;
        ready         = 1'b0;
        rvalid        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    cyc_d      = bus.req_cyctype_dir;
                    // I/O addresses are left-aligned so both sizes shift out from [31:28].
                    addr_d     = is_mem(bus.req_cyctype_dir) ? bus.req_addr
                                                             : {bus.req_addr[15:0], 16'h0000};
                    wdata_d    = bus.req_data;
                    sync_err_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                frame   = 1'b0;
                ad_oe   = 1'b1;
                ad_out  = 4'h0;
                state_d = ST_CYCTYPE;
            end
            ST_CYCTYPE: begin
                ad_oe   = 1'b1;
                ad_out  = cyc_q;
                cnt_d   = is_mem(cyc_q) ? 3'd7 : 3'd3;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                ad_oe  = 1'b1;
                ad_out = addr_q[31:28];
                addr_d = {addr_q[27:0], 4'h0};
                if (cnt_q == 3'd0) begin
                    if (is_write(cyc_q)) begin
                        cnt_d   = 3'd1;
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_TAR_H1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WDATA: begin
                ad_oe   = 1'b1;
                ad_out  = wdata_q[3:0];
                wdata_d = {4'h0, wdata_q[7:4]};
                if (cnt_q == 3'd0) begin
                    state_d = ST_TAR_H1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_TAR_H1: begin
                ad_oe   = 1'b1;
                ad_out  = 4'hF;
                state_d = ST_TAR_H2;
            end
            ST_TAR_H2: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                case (bus.lpc_ad_in)
                    SYNC_READY, SYNC_ERROR: begin
                        sync_err_d = (bus.lpc_ad_in == SYNC_ERROR);
                        if (is_write(cyc_q)) begin
                            state_d = ST_TAR_T1;
                        end else begin
                            cnt_d   = 3'd1;
                            state_d = ST_RDATA;
                        end
                    end
                    default: begin
                        // Short/long wait and any unknown code (incl. 1111) keep waiting.
`ifdef LPC_HOST_TIMEOUT_EN
                        if (tmo_expired) begin
                            cnt_d   = 3'd3;
                            state_d = ST_ABORT;
                        end
`endif
                    end
                endcase
            end
            ST_RDATA: begin
                // Low nibble arrives first; it ends up in [3:0] after the second shift.
                rdata_d = {bus.lpc_ad_in, rdata_q[7:4]};
                if (cnt_q == 3'd0) begin
                    state_d = ST_TAR_T1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_TAR_T1: begin
                state_d = ST_TAR_T2;
            end
            ST_TAR_T2: begin
                resp_status_d = sync_err_q ? STAT_SYNC_ERR : STAT_OK;
                if (!is_write(cyc_q)) begin
                    resp_data_d = rdata_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rvalid  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef LPC_HOST_TIMEOUT_EN
            ST_ABORT: begin
                frame  = 1'b0;
                ad_oe  = 1'b1;
                ad_out = 4'hF;
                if (cnt_q == 3'd0) begin
                    state_d = ST_ABORT_END;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ABORT_END: begin
                resp_status_d = STAT_ABORT;
                resp_data_d   = 8'hFF;
                state_d       = ST_RESP;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            cyc_q         <= 4'h0;
            addr_q        <= 32'h0;
            wdata_q       <= 8'h00;
            rdata_q       <= 8'h00;
            sync_err_q    <= 1'b0;
            resp_data_q   <= 8'h00;
            resp_status_q <= STAT_OK;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cyc_q         <= cyc_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            sync_err_q    <= sync_err_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.resp_valid  = rvalid;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_status = resp_status_q;
    assign bus.lpc_frame   = frame;
    assign bus.lpc_ad_oe   = ad_oe;
    assign bus.lpc_ad_out  = ad_out;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: directed bench for lpc_host with scoreboard queues.
// The stimulus task pushes the expected LAD nibbles and the expected response;
// a monitor pops and compares whenever LAD is driven or resp_valid is high.
// Cycle k of a request is the k-th clock period after the acceptance edge.
module tb_lpc_host;
    import lpc_pkg::*;

    localparam int TMO = 8;

    typedef struct {
        bit         chk_data;
        logic [7:0] data;
        logic [1:0] status;
        int         lat;
    } resp_t;

    logic clock;
    logic reset;
    int   pc = 0;
    int   acc = 0;
    int   resp_seen = 0;
    int   checks = 0;
    int   errors = 0;

    logic [4:0] lad_q[$];
    resp_t      resp_q[$];

    lpc_host_if bus ();

    lpc_host #(
        .SYNC_TIMEOUT (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) pc <= pc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lad_push(inout int c, input int mode, input logic [4:0] e);
        // A request reset in ADDR only ever drives cycles 1..4.
        if (mode != 1 || c <= 4) lad_q.push_back(e);
        c++;
    endtask

    function automatic logic [3:0] tgt_nib(input int k, input int s0, input int nwait,
                                           input logic [3:0] wcode, input logic [3:0] fcode,
                                           input logic [7:0] rd, input bit wr);
        if (k >= s0 && k < s0 + nwait) return wcode;
        if (k == s0 + nwait) return fcode;
        if (!wr && k == s0 + nwait + 1) return rd[3:0];
        if (!wr && k == s0 + nwait + 2) return rd[7:4];
        return 4'hF;
    endfunction

    // mode 0: normal completion, 1: reset during ADDR, 2: SYNC never completes
    // Called and returns at a negative clock edge.
    task automatic issue(input logic [3:0] ct, input logic [31:0] addr, input logic [7:0] wd,
                         input int nwait, input logic [3:0] wcode, input logic [3:0] fcode,
                         input logic [7:0] rd, input int mode);
        bit          mem, wr;
        int          s0, lat, last, c, guard, seen0;
        logic [31:0] a;
        resp_t       r;
        mem   = (ct[3:2] == 2'b01);
        wr    = ct[1];
        s0    = 9 + (mem ? 4 : 0) + (wr ? 2 : 0);
        lat   = s0 + nwait + (wr ? 3 : 5);
        guard = 0;
        while (!bus.req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("req_ready_idle", bus.req_ready, 1);
        check("frame_idle", bus.lpc_frame, 1);
        bus.req_valid       = 1'b1;
        bus.req_cyctype_dir = ct;
        bus.req_addr        = addr;
        bus.req_data        = wd;
        @(posedge clock);
        #1;
        acc   = pc;
        seen0 = resp_seen;
        bus.req_valid       = 1'b0;
        bus.req_cyctype_dir = 4'($urandom);
        bus.req_addr        = $urandom;
        bus.req_data        = 8'($urandom);

        c = 1;
        lad_push(c, mode, {1'b0, 4'h0});
        lad_push(c, mode, {1'b1, ct});
        a = mem ? addr : {addr[15:0], 16'h0000};
        for (int i = 0; i < (mem ? 8 : 4); i++) begin
            lad_push(c, mode, {1'b1, a[31:28]});
            a = a << 4;
        end
        if (wr) begin
            lad_push(c, mode, {1'b1, wd[3:0]});
            lad_push(c, mode, {1'b1, wd[7:4]});
        end
        lad_push(c, mode, {1'b1, 4'hF});

        last = lat;
        if (mode == 0) begin
            r.chk_data = !wr;
            r.data     = rd;
            r.status   = (fcode == SYNC_ERROR) ? 2'b01 : 2'b00;
            r.lat      = lat;
            resp_q.push_back(r);
        end else if (mode == 1) begin
            last = 4;
        end else begin
`ifdef LPC_HOST_TIMEOUT_EN
            for (int i = 0; i < 4; i++) lad_q.push_back({1'b0, 4'hF});
            last       = s0 + TMO + 5;
            r.chk_data = 1'b1;
            r.data     = 8'hFF;
            r.status   = 2'b10;
            r.lat      = last;
            resp_q.push_back(r);
`else
            last = s0 + 40;
`endif
        end

        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            bus.lpc_ad_in = tgt_nib(k, s0, nwait, wcode, fcode, rd, wr);
            if (k == 1) check("req_ready_busy", bus.req_ready, 0);
        end

        if (mode == 0 || (mode == 2 && resp_q.size() + resp_seen - seen0 > 0)) begin
            @(negedge clock);
            bus.lpc_ad_in = 4'hF;
            check("resp_count", resp_seen - seen0, 1);
            check("req_ready_after_resp", bus.req_ready, 1);
        end else begin
            if (mode == 2) check("no_resp_while_waiting", resp_seen - seen0, 0);
            reset = 1'b1;
            @(negedge clock);
            check("rst_frame", bus.lpc_frame, 1);
            check("rst_oe", bus.lpc_ad_oe, 0);
            check("rst_ready", bus.req_ready, 1);
            check("rst_resp_valid", bus.resp_valid, 0);
            reset = 1'b0;
            bus.lpc_ad_in = 4'hF;
        end
    endtask

    // Monitor: LAD nibbles and responses against the scoreboard.
    initial begin
        logic [4:0] e;
        resp_t      r;
        forever begin
            @(negedge clock);
            if (bus.lpc_ad_oe) begin
                if (lad_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lad_unexpected actual=%0h required=none", {bus.lpc_frame, bus.lpc_ad_out});
                end else begin
                    e = lad_q.pop_front();
                    check("lad_frame_nibble", {27'h0, bus.lpc_frame, bus.lpc_ad_out}, {27'h0, e});
                end
            end
            if (bus.resp_valid) begin
                resp_seen++;
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual=%0h required=none", bus.resp_status);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_status", bus.resp_status, r.status);
                    if (r.chk_data) check("resp_data", bus.resp_data, r.data);
                    check("resp_latency", pc - acc + 1, r.lat);
                    check("ready_during_resp", bus.req_ready, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        reset               = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_cyctype_dir = 4'h0;
        bus.req_addr        = 32'h0;
        bus.req_data        = 8'h00;
        bus.lpc_ad_in       = 4'hF;
        repeat (3) @(negedge clock);
        check("reset_frame", bus.lpc_frame, 1);
        check("reset_oe", bus.lpc_ad_oe, 0);
        check("reset_ad_out", bus.lpc_ad_out, 4'hF);
        check("reset_ready", bus.req_ready, 1);
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_resp_data", bus.resp_data, 8'h00);
        check("reset_resp_status", bus.resp_status, 2'b00);
        reset = 1'b0;

        issue(CYC_IO_WR,  32'h0000_0080, 8'h5A, 0, 4'h6, SYNC_READY, 8'h00, 0);
        issue(CYC_MEM_RD, 32'hFFFF_FFF0, 8'h00, 0, 4'h6, SYNC_READY, 8'h3C, 0);
        issue(CYC_IO_RD,  32'h1234_0060, 8'h00, 3, 4'h6, SYNC_READY, 8'hA5, 0);
        issue(CYC_IO_RD,  32'h0000_0064, 8'h00, 0, 4'h6, SYNC_ERROR, 8'h81, 0);
        issue(CYC_MEM_WR, 32'h000C_D800, 8'h7E, 2, 4'h5, SYNC_READY, 8'h00, 0);
        issue(CYC_IO_WR,  32'h0000_0400, 8'h11, 1, 4'hF, SYNC_ERROR, 8'h00, 0);
        issue(CYC_IO_RD,  32'h0000_0080, 8'h00, 1000, 4'hF, SYNC_READY, 8'h00, 2);
        issue(CYC_IO_WR,  32'h0000_0080, 8'h5A, 0, 4'h6, SYNC_READY, 8'h00, 1);
        issue(CYC_IO_RD,  32'h0000_02E8, 8'h00, 0, 4'h6, SYNC_READY, 8'hC3, 0);

        repeat (4) @(negedge clock);
        check("lad_queue_drained", lad_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
